// File: rtl/aes_decrypt_core.sv
// Iterative AES inverse cipher (AES-128/192/256), one round per clock.
// Round keys come from an external store addressed combinationally by key_addr.
// Byte s[r][c] of every 128-bit block sits at bits [32c+8r+7 : 32c+8r].
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. ct_ready is high only in IDLE and pt_valid only in DONE. Once
// raised, pt_valid holds with plaintext unchanged until pt_ready is seen.
module aes_decrypt_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         ct_valid,
  output logic         ct_ready,
  input  logic [127:0] ciphertext,
  input  logic [3:0]   nr,
  output logic [3:0]   key_addr,
  input  logic [127:0] round_key,
  output logic         pt_valid,
  input  logic         pt_ready,
  output logic [127:0] plaintext,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         fsm_q;
  logic [127:0] state_q;
  logic [3:0]   rnd_q;
  logic [3:0]   nr_q;

  logic [3:0]   nr_eff;
  logic [127:0] t_sub;
  logic [127:0] t_key;
  logic [127:0] mixed;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128 (0 maps to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine transform, then invert in GF(2^8).
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // Out-of-range round counts fall back to AES-128.
  always_comb begin
    nr_eff = 4'd10;
    if (nr == 4'd10 || nr == 4'd12 || nr == 4'd14) nr_eff = nr;
  end

  // One inverse round: InvShiftRows + InvSubBytes, key add, InvMixColumns.
  always_comb begin
    t_sub = '0;
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t_sub[8*(4*((c+r)%4)+r) +: 8] = inv_sbox(state_q[8*(4*c+r) +: 8]);
      end
    end
    t_key = t_sub ^ round_key;
    for (int c = 0; c < 4; c++) begin
      mixed[32*c+0  +: 8] = gmul(t_key[32*c +: 8], 8'h0e) ^ gmul(t_key[32*c+8 +: 8], 8'h0b) ^
                            gmul(t_key[32*c+16 +: 8], 8'h0d) ^ gmul(t_key[32*c+24 +: 8], 8'h09);
      mixed[32*c+8  +: 8] = gmul(t_key[32*c +: 8], 8'h09) ^ gmul(t_key[32*c+8 +: 8], 8'h0e) ^
                            gmul(t_key[32*c+16 +: 8], 8'h0b) ^ gmul(t_key[32*c+24 +: 8], 8'h0d);
      mixed[32*c+16 +: 8] = gmul(t_key[32*c +: 8], 8'h0d) ^ gmul(t_key[32*c+8 +: 8], 8'h09) ^
                            gmul(t_key[32*c+16 +: 8], 8'h0e) ^ gmul(t_key[32*c+24 +: 8], 8'h0b);
      mixed[32*c+24 +: 8] = gmul(t_key[32*c +: 8], 8'h0b) ^ gmul(t_key[32*c+8 +: 8], 8'h0d) ^
                            gmul(t_key[32*c+16 +: 8], 8'h09) ^ gmul(t_key[32*c+24 +: 8], 8'h0e);
    end
  end

  // Status and key index decode; everything is forced low while in reset.
  always_comb begin
    ct_ready = 1'b0;
    pt_valid = 1'b0;
    busy     = 1'b0;
    key_addr = 4'd0;
    if (!rst) begin
      case (fsm_q)
        IDLE: begin
          ct_ready = 1'b1;
          key_addr = nr_eff;
        end
        ROUND: begin
          busy     = 1'b1;
          key_addr = rnd_q;
        end
        DONE: begin
          busy     = 1'b1;
          pt_valid = 1'b1;
        end
        default: key_addr = 4'd0;
      endcase
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= IDLE;
      state_q   <= '0;
      plaintext <= '0;
      rnd_q     <= '0;
      nr_q      <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (ct_valid) begin
            state_q <= ciphertext ^ round_key;
            nr_q    <= nr_eff;
            rnd_q   <= nr_eff - 4'd1;
            fsm_q   <= ROUND;
          end
        end
        ROUND: begin
          if (rnd_q != 4'd0) begin
            state_q <= mixed;
            rnd_q   <= rnd_q - 4'd1;
          end else begin
            plaintext <= t_key;
            fsm_q     <= DONE;
          end
        end
        DONE: begin
          if (pt_ready) fsm_q <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  // The round index always stays below the latched round count.
  rnd_in_range: assert property (@(posedge clk) disable iff (rst)
    (fsm_q == ROUND) |-> (rnd_q < nr_q));

endmodule

// File: doc/aes_decrypt_core.md
# aes_decrypt_core

Iterative AES inverse-cipher core, one round per clock, covering AES-128/192/256 (Nr = 10/12/14). It is the receive-side counterpart of the encrypt core. It takes a ciphertext block, reads round keys from the shared external round-key store by round index, and returns the plaintext. The byte ordering matches the encrypt core, so a block encrypted there decrypts here unchanged.

## Interface
Parameters: none.

- `clk`  in  1  sole clock; everything is on the rising edge.
- `rst`  in  1  reset. **Synchronous, active-high.**
- `ct_valid`  in  1  `ciphertext` is valid.
- `ct_ready`  out  1  core accepts a block (IDLE only).
- `ciphertext`  in  128  input block.
  - State byte s[r][c] sits at bits [32c+8r+7 : 32c+8r], so byte 0 is at the LSB.
- `nr`  in  4  round count, sampled at accept.
- `key_addr`  out  4  round-key index requested this cycle (combinational).
- `round_key`  in  128  round key w[key_addr], same byte order.
  - Must be valid combinationally in the same cycle as `key_addr`.
- `pt_valid`  out  1  `plaintext` is valid (DONE only).
- `pt_ready`  in  1  downstream takes the plaintext.
- `plaintext`  out  128  result, registered.
- `busy`  out  1  high in ROUND or DONE.

## Operation
- FSM states: IDLE, ROUND, DONE. Internal registers:
  - `state_q` (128)
  - `rnd_q` (4)
  - `nr_q` (4)
- Effective nr:
  - 10, 12 and 14 are used as given.
  - Any other value is clamped to 10.
- IDLE:
  - `ct_ready`=1 and `key_addr`=effective `nr`.
  - On `ct_valid`&&`ct_ready`: `state_q` ← `ciphertext` ^ `round_key`, `nr_q` ← eff nr, `rnd_q` ← eff nr − 1, go to ROUND.
- ROUND: `key_addr`=`rnd_q`; let t = InvSubBytes(InvShiftRows(`state_q`)).
  - If `rnd_q`≠0: `state_q` ← InvMixColumns(t ^ `round_key`), then `rnd_q` decrements.
  - If `rnd_q`=0: `plaintext` ← t ^ `round_key`, go to DONE.
- DONE:
  - `pt_valid`=1, `key_addr`=0.
  - `plaintext` holds stable until `pt_valid`&&`pt_ready`, then go to IDLE.
- Round operations:
  - InvShiftRows rotates row r right by r columns: s'[r][(c+r)%4] = s[r][c].
  - InvMixColumns uses the matrix {0e,0b,0d,09} over GF(2^8), reduction polynomial 0x11B.
  - InvSubBytes is the FIPS-197 inverse S-box.
- `ct_valid`/`ciphertext`/`nr` are ignored outside IDLE. `pt_ready` is ignored outside DONE.
- Reset:
  - `rst` high at any edge, including mid-ROUND or mid-DONE, forces IDLE.
  - Registers clear: `state_q`, `plaintext`, `rnd_q`, `nr_q` ← 0.
  - Any block in flight is discarded and no `pt_valid` is produced for it.
- Outputs while `rst` is high: `ct_ready`=0, `pt_valid`=0, `busy`=0, `key_addr`=0. After reset, `plaintext`=0.

## Timing
- Accept edge E0 (first key used: w[Nr]).
- ROUND edges E1..E(Nr) use keys w[Nr−1] down to w[0].
- `pt_valid` rises in the cycle after E(Nr), i.e. Nr+1 cycles after acceptance:
  - 11 cycles for AES-128
  - 13 cycles for AES-192
  - 15 cycles for AES-256
- If `pt_ready` is held high, DONE lasts 1 cycle and IDLE 1 cycle. Minimum block period is Nr+2 cycles.
- `key_addr` sequence per block: Nr, Nr−1, …, 1, 0, with one value per cycle.
- `pt_valid`, once high, stays high with `plaintext` unchanged until the handshake completes.

## Test plan
- **AES-128, FIPS-197 C.1.**
  - Stimulus: key 000102…0f, `ciphertext`=128'h5ac5b47080b7cdd830047b6ad8e0c469, `nr`=10, bench supplies round keys.
  - Required: `plaintext`=128'hffeeddccbbaa99887766554433221100; `pt_valid` 11 cycles after accept; `key_addr` steps 10→0.
- **AES-256, FIPS-197 C.3.**
  - Stimulus: `ciphertext`=128'h8960494b9049fceabf456751cab7a28e, `nr`=14.
  - Required: same `plaintext`, 15-cycle latency. Repeat with C.2 (AES-192, `nr`=12): 13-cycle latency.
- **Backpressure.**
  - Stimulus: `pt_ready`=0 for 20 cycles after `pt_valid` rises; toggle `ct_valid` during DONE.
  - Required: `pt_valid` and `plaintext` stable; `ct_ready`=0; no new block accepted.
- **Back-to-back with `pt_ready`=1.**
  - Stimulus: 4 random blocks against a reference model.
  - Required: all results match; accepts spaced exactly Nr+2 cycles apart.
- **Reset mid-operation.**
  - Stimulus: assert `rst` for 1 cycle at ROUND with `rnd_q`=5.
  - Required: next cycle IDLE, `ct_ready`=1, `plaintext`=0, `pt_valid` never asserted for that block.
- **Illegal nr.**
  - Stimulus: `nr`=7 with the C.1 vector.
  - Required: behaves as `nr`=10, correct C.1 plaintext, `key_addr` starts at 10.
